fp32_uart_operand_tx: RTL and testbench

//   Host-side UART transmitter for the fp32 MAC link: accepts one 96-bit operand bundle
//   {acc, bravo, alpha} over a valid/ready handshake and serialises it as 12 UART 8N1 frames.
//   It is the sending end of the operand stream that fp32_uart_rx reassembles. It sits in the

---
 rtl/fp32_uart_operand_tx.sv | 139 +++++++++++++
 tb/tb_fp32_uart_operand_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_uart_operand_tx.sv
// UART 8N1 transmitter for one 96-bit fp32 operand bundle {acc, bravo, alpha}.
// Sends 12 frames LSB byte first, with optional idle mark bit-times after each stop bit.
module fp32_uart_operand_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_BITS     = 0
) (
    input  logic        CLK_I,
    input  logic        RSTL_I,
    input  logic        TX_VALID_I,
    input  logic [95:0] TX_DATA_I,
    output logic        TX_READY_O,
    output logic        UART_TX_O,
    output logic        BUSY_O,
    output logic [2:0]  fsm_state
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam bit            HAS_GAP   = (GAP_BITS > 0);
    localparam logic [3:0]    GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    // Handshake: a bundle moves on a CLK_I edge where TX_VALID_I and TX_READY_O are both
    // high; TX_READY_O only depends on registered state, and TX_DATA_I is sampled only then.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t         state_q, state_n;
    logic [BW-1:0]  baud_q, baud_n;
    logic [2:0]     bit_q, bit_n;
    logic [3:0]     gap_q, gap_n;
    logic [3:0]     byte_q, byte_n;
    logic [95:0]    shreg_q, shreg_n;
    logic           bit_end, frame_tail;
    logic           tx_n, ready_n, busy_n;

    assign fsm_state = state_q;

    always_comb begin
        state_n    = state_q;
        baud_n     = (baud_q == BAUD_LAST) ? '0 : baud_q + BW'(1);
        bit_n      = bit_q;
        gap_n      = gap_q;
        byte_n     = byte_q;
        shreg_n    = shreg_q;
        bit_end    = (baud_q == BAUD_LAST);
        frame_tail = HAS_GAP ? (state_q == S_GAP && gap_q == GAP_LAST) : (state_q == S_STOP);

        case (state_q)
            S_IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                gap_n  = '0;
                byte_n = '0;
                if (TX_VALID_I && TX_READY_O) begin
                    state_n = S_START;
                    shreg_n = TX_DATA_I;
                end
            end
            S_START: if (bit_end) state_n = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = {1'b0, shreg_q[95:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (HAS_GAP) begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end else begin
                        state_n = S_START;
                        byte_n  = byte_q + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_n = S_START;
                        gap_n   = '0;
                        byte_n  = byte_q + 4'd1;
                    end else begin
                        gap_n = gap_q + 4'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // The last cycle of the final mark bit is spent in IDLE with ready already up, so a
        // waiting bundle is accepted on the edge that ends that bit and its start bit follows
        // with no extra idle cycle; the line is mark in IDLE, so the bit length is unchanged.
        if (frame_tail && byte_q == 4'd11 && baud_q == BAUD_PRE) begin
            state_n = S_IDLE;
            baud_n  = '0;
            bit_n   = '0;
            gap_n   = '0;
            byte_n  = '0;
        end

        tx_n    = (state_n == S_START) ? 1'b0 :
                  (state_n == S_DATA)  ? shreg_n[0] : 1'b1;
        ready_n = (state_n == S_IDLE);
        busy_n  = (state_n != S_IDLE);
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            UART_TX_O  <= 1'b1;
            TX_READY_O <= 1'b0;
            BUSY_O     <= 1'b0;
        end else begin
            state_q    <= state_n;
            baud_q     <= baud_n;
            bit_q      <= bit_n;
            gap_q      <= gap_n;
            byte_q     <= byte_n;
            shreg_q    <= shreg_n;
            UART_TX_O  <= tx_n;
            TX_READY_O <= ready_n;
            BUSY_O     <= busy_n;
        end
    end

endmodule

// File: tb/tb_fp32_uart_operand_tx.sv
// Bench for fp32_uart_operand_tx: vector table plus hand sequences, with a UART frame
// decoder popping expected bytes from a queue filled when each bundle is driven.
module tb_fp32_uart_operand_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, valid_g = 1'b0;
    logic [95:0] data = '0, data_g = '0;
    logic        ready, line, busy, ready_g, line_g, busy_g;
    logic [2:0]  st, st_g;
    logic        sel_gap = 1'b0;
    logic        mon_line;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [95:0] data;
        logic [95:0] exp_seq;  // first transmitted byte in [95:88]
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    fp32_uart_operand_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid), .TX_DATA_I(data),
        .TX_READY_O(ready), .UART_TX_O(line), .BUSY_O(busy), .fsm_state(st)
    );

    fp32_uart_operand_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut_gap (
        .CLK_I(clk), .RSTL_I(rst_n), .TX_VALID_I(valid_g), .TX_DATA_I(data_g),
        .TX_READY_O(ready_g), .UART_TX_O(line_g), .BUSY_O(busy_g), .fsm_state(st_g)
    );

    assign mon_line = sel_gap ? line_g : line;

    function automatic void check(string name, logic [95:0] got, logic [95:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    function automatic logic [95:0] byte_seq(logic [95:0] d);
        logic [95:0] s;
        for (int k = 0; k < 12; k++) s[95-8*k -: 8] = d[8*k +: 8];
        return s;
    endfunction

    task automatic push_seq(input logic [95:0] s);
        for (int i = 0; i < 12; i++) exp_q.push_back(s[95-8*i -: 8]);
    endtask

    // Returns just after the accepting edge; cycle 0 is the cycle that follows it.
    task automatic send_bundle(input bit g, input logic [95:0] d, input logic [95:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (((g ? ready_g : ready) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", (g ? ready_g : ready), 1'b1);
        if (n < 3000) begin
            if (g) begin valid_g = 1'b1; data_g = d; end
            else   begin valid = 1'b1; data = d; end
            push_seq(s);
            @(posedge clk);
            #1;
            valid = 1'b0; valid_g = 1'b0;
            data = 'x; data_g = 'x;
        end
    endtask

    // Frame decoder: start seen in its first cycle, data sampled one cycle into each bit.
    initial begin
        logic [7:0] b;
        logic [7:0] w;
        bit ab, ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_line === 1'b0) begin
                b = '0; ab = 1'b0; ok = 1'b1;
                for (int c = 1; c <= 37; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ab = 1'b1;
                    if (c == 1 && mon_line !== 1'b0) ok = 1'b0;
                    if (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) b[(c-5)/4] = mon_line;
                    if (c == 37 && mon_line !== 1'b1) ok = 1'b0;
                end
                if (!ab) begin
                    check("frame_format", ok, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h expected no frame", b);
                    end else begin
                        w = exp_q.pop_front();
                        check("frame_byte", b, w);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  pat;
        logic [39:0] got40, exp40;
        logic [95:0] d2, s2, rd;
        logic        e;
        int          bad, ret;

        vt[0].data = 96'h3F800000_40000000_40400000; vt[0].exp_seq = 96'h00004040_00000040_0000803F;
        vt[1].data = 96'h000000A5;                   vt[1].exp_seq = 96'hA5000000_00000000_00000000;
        vt[2].data = 96'h0C0B0A09_08070605_04030201; vt[2].exp_seq = 96'h01020304_05060708_090A0B0C;
        vt[3].data = {96{1'b1}};                     vt[3].exp_seq = {96{1'b1}};
        vt[4].data = 96'h80000000_00000000_00000001; vt[4].exp_seq = 96'h01000000_00000000_00000080;
        vt[5].data = 96'h12345678_9ABCDEF0_0F1E2D3C; vt[5].exp_seq = 96'h3C2D1E0F_F0DEBC9A_78563412;
        for (int i = 6; i < 8; i++) begin
            vt[i].data    = {$urandom(), $urandom(), $urandom()};
            vt[i].exp_seq = byte_seq(vt[i].data);
        end

        // reset state, then ready one edge after release
        repeat (3) @(negedge clk);
        check("rst_line", line, 1'b1);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", ready, 1'b0);
        @(negedge clk);
        check("ready_after_rst", ready, 1'b1);

        // table: each bundle decoded byte by byte; ready back for the handshake cycle
        // that would let a following start bit land at cycle 480
        for (int i = 0; i < 8; i++) begin
            send_bundle(1'b0, vt[i].data, vt[i].exp_seq);
            for (int c = 0; c < 480; c++) begin
                @(negedge clk);
                if (c == 0)   begin check("busy_after_accept", busy, 1'b1); check("ready_after_accept", ready, 1'b0); end
                if (c == 478) check("ready_late", ready, 1'b0);
                if (c == 479) begin check("ready_return", ready, 1'b1); check("busy_return", busy, 1'b0); end
            end
            check("queue_drained", exp_q.size(), 0);
        end

        // bit timing of the first frame of 0xA5
        pat = 10'b0101001011;
        for (int c = 0; c < 40; c++) exp40[39-c] = pat[9 - c/4];
        @(negedge clk);
        check("idle_line", line, 1'b1);
        send_bundle(1'b0, 96'h000000A5, 96'hA5000000_00000000_00000000);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            got40[39-c] = line;
        end
        check("bit_timing", got40, exp40);
        repeat (445) @(negedge clk);
        check("a5_drained", exp_q.size(), 0);

        // back-to-back with valid held; data changes while busy are ignored
        @(negedge clk);
        valid = 1'b1;
        data  = vt[2].data;
        push_seq(vt[2].exp_seq);
        @(posedge clk);
        #1 data = 96'h5A5A5A5A_5A5A5A5A_5A5A5A5A;
        ret = -1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 100) data = {$urandom(), $urandom(), $urandom()};
            if (c == 470) begin data = vt[5].data; push_seq(vt[5].exp_seq); end
            if (c == 478) check("b2b_ready_early", ready, 1'b0);
            if (c == 479) begin check("b2b_ready", ready, 1'b1); check("b2b_stop_line", line, 1'b1); end
            if (c == 480) begin
                check("b2b_second_start", line, 1'b0);
                check("b2b_busy", busy, 1'b1);
                valid = 1'b0;
                data  = 'x;
            end
            if (c > 480 && ret < 0 && ready === 1'b1) ret = c;
        end
        check("b2b_span", ret + 1, 960);
        check("b2b_drained", exp_q.size(), 0);

        // GAP_BITS=2: 8 mark cycles after each stop bit, 576-cycle bundle
        sel_gap = 1'b1;
        d2 = vt[0].data;
        s2 = vt[0].exp_seq;
        send_bundle(1'b1, d2, s2);
        bad = 0;
        for (int c = 0; c < 576; c++) begin
            @(negedge clk);
            if ((c % 48) / 4 == 0)      e = 1'b0;
            else if ((c % 48) / 4 <= 8) e = d2[8*(c/48) + (c % 48)/4 - 1];
            else                        e = 1'b1;
            if (line_g !== e) bad++;
            if (c == 574) check("gap_ready_late", ready_g, 1'b0);
            if (c == 575) check("gap_ready_return", ready_g, 1'b1);
        end
        check("gap_line_mismatches", bad, 0);
        check("gap_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        sel_gap = 1'b0;

        // reset during byte 5, bit 3
        send_bundle(1'b0, d2, s2);
        for (int c = 0; c <= 217; c++) @(negedge clk);
        check("pre_reset_line", line, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_line", line, 1'b1);
        check("async_rst_ready", ready, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("bytes_left_at_reset", exp_q.size(), 7);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (line !== 1'b1) bad++;
        end
        check("no_residual_frame", bad, 0);
        rd = {$urandom(), $urandom(), $urandom()};
        send_bundle(1'b0, rd, byte_seq(rd));
        repeat (485) @(negedge clk);
        check("post_reset_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
